// File: rtl/fifo8x16.sv
// Eight-entry, 16-bit first-word-fall-through FIFO on a single clock.
// Write-side one-hot load decode, read-side pointer-selected mux, registered reject pulse.
module fifo8x16 (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        push,
    input  logic        pop,
    output logic [15:0] out,
    output logic        empty,
    output logic        full,
    output logic [3:0]  count,
    output logic        err
);

    logic [2:0]  wptr_reg, wptr_next;
    logic [2:0]  rptr_reg, rptr_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        err_reg, err_next;
    logic [15:0] mem_reg [8];
    logic [7:0]  load;
    logic        push_acc;
    logic        pop_acc;
    logic [15:0] head;

    assign empty = (cnt_reg == 4'd0);
    assign full  = (cnt_reg == 4'd8);
    assign count = cnt_reg;
    assign err   = err_reg;

    // A pop at full frees the slot the push is about to fill, so both proceed.
    assign push_acc = push & (~full | pop);
    assign pop_acc  = pop & ~empty;

    always_comb begin
        load           = 8'd0;
        load[wptr_reg] = push_acc;
    end

    // Storage is never reset; empty masks any stale word on the output.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mem
            always_ff @(posedge clock) begin
                if (load[gi]) begin
                    mem_reg[gi] <= in;
                end
            end
        end
    endgenerate

    assign head = mem_reg[rptr_reg];
    assign out  = empty ? 16'h0000 : head;

    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        cnt_next  = cnt_reg;
        err_next  = (push & ~push_acc) | (pop & ~pop_acc);
        if (push_acc) begin
            wptr_next = wptr_reg + 3'd1;
        end
        if (pop_acc) begin
            rptr_next = rptr_reg + 3'd1;
        end
        if (push_acc && !pop_acc) begin
            cnt_next = cnt_reg + 4'd1;
        end else if (pop_acc && !push_acc) begin
            cnt_next = cnt_reg - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_reg <= 3'd0;
            rptr_reg <= 3'd0;
            cnt_reg  <= 4'd0;
            err_reg  <= 1'b0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
            cnt_reg  <= cnt_next;
            err_reg  <= err_next;
        end
    end

endmodule

// File: tb/tb_fifo8x16.sv
// Self-checking bench for fifo8x16: directed scenarios plus randomized traffic
// compared against a queue-based model of the FIFO.
module tb_fifo8x16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [15:0] in = 16'h0000;
    logic [15:0] out;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        err;

    logic [15:0] mq[$];
    logic        exp_err = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clock = ~clock;

    fifo8x16 dut (
        .clock(clock),
        .reset(reset),
        .in(in),
        .push(push),
        .pop(pop),
        .out(out),
        .empty(empty),
        .full(full),
        .count(count),
        .err(err)
    );

    function automatic logic [15:0] exp_out();
        return (mq.size() != 0) ? mq[0] : 16'h0000;
    endfunction

    // Drive one cycle of stimulus, advance the model, leave time at edge+1.
    task automatic step(input logic r, input logic p, input logic q, input logic [15:0] d);
        logic pa;
        logic qa;
        reset = r;
        push  = p;
        pop   = q;
        in    = d;
        pa = p && ((mq.size() < 8) || q);
        qa = q && (mq.size() != 0);
        @(posedge clock);
        #1;
        if (r) begin
            mq.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = (p && !pa) || (q && !qa);
            if (qa) void'(mq.pop_front());
            if (pa) mq.push_back(d);
        end
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        $display("tx rst=%0b push=%0b pop=%0b in=%h -> count=%0d out=%h empty=%0b full=%0b err=%0b",
                 r, p, q, d, count, out, empty, full, err);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        n_total++; if (out !== 16'h0000) $display("FAIL reset_out got=%h want=0000", out); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b want=1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got=%b want=0", full); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d want=0", count); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err); else n_pass++;
        step(1'b1, 1'b1, 1'b0, 16'h1234);
        n_total++; if (count !== 4'd0) $display("FAIL reset_prio_count got=%0d want=0", count); else n_pass++;
        n_total++; if (empty !== 1'b1) $display("FAIL reset_prio_empty got=%b want=1", empty); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'(i));
            n_total++; if (count !== 4'(i)) $display("FAIL fill_count got=%0d want=%0d", count, i); else n_pass++;
        end
        n_total++; if (full !== 1'b1) $display("FAIL fill_full got=%b want=1", full); else n_pass++;
        n_total++; if (out !== 16'h0001) $display("FAIL fill_head got=%h want=0001", out); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 16'h0009);
        n_total++; if (err !== 1'b1) $display("FAIL overflow_err got=%b want=1", err); else n_pass++;
        n_total++; if (count !== 4'd8) $display("FAIL overflow_count got=%0d want=8", count); else n_pass++;
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        n_total++; if (err !== 1'b0) $display("FAIL err_one_cycle got=%b want=0", err); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            n_total++; if (out !== 16'(i)) $display("FAIL drain_out got=%h want=%h", out, 16'(i)); else n_pass++;
            step(1'b0, 1'b0, 1'b1, 16'h0000);
        end
        n_total++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b want=1", empty); else n_pass++;
        n_total++; if (out !== 16'h0000) $display("FAIL drain_out_zero got=%h want=0000", out); else n_pass++;
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        n_total++; if (err !== 1'b1) $display("FAIL underflow_err got=%b want=1", err); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL underflow_count got=%0d want=0", count); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'($urandom));
        for (int i = 0; i < 5; i++) begin
            n_total++; if (out !== exp_out()) $display("FAIL wrap_pre_out got=%h want=%h", out, exp_out()); else n_pass++;
            step(1'b0, 1'b0, 1'b1, 16'h0000);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 16'hA000 + 16'(i));
        n_total++; if (count !== 4'd6) $display("FAIL wrap_count got=%0d want=6", count); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++; if (out !== 16'hA000 + 16'(i)) $display("FAIL wrap_out got=%h want=%h", out, 16'hA000 + 16'(i)); else n_pass++;
            step(1'b0, 1'b0, 1'b1, 16'h0000);
        end
        n_total++; if (empty !== 1'b1) $display("FAIL wrap_empty got=%b want=1", empty); else n_pass++;
    endtask

    task automatic test_full_pushpop();
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
        step(1'b0, 1'b1, 1'b1, 16'hBEEF);
        n_total++; if (count !== 4'd8) $display("FAIL fullpp_count got=%0d want=8", count); else n_pass++;
        n_total++; if (out !== 16'h0102) $display("FAIL fullpp_out got=%h want=0102", out); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL fullpp_err got=%b want=0", err); else n_pass++;
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 16'h0000);
        n_total++; if (out !== 16'hBEEF) $display("FAIL fullpp_tail got=%h want=beef", out); else n_pass++;
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        n_total++; if (empty !== 1'b1) $display("FAIL fullpp_empty got=%b want=1", empty); else n_pass++;
    endtask

    task automatic test_empty_pushpop();
        step(1'b0, 1'b1, 1'b1, 16'h5A5A);
        n_total++; if (err !== 1'b1) $display("FAIL emptypp_err got=%b want=1", err); else n_pass++;
        n_total++; if (count !== 4'd1) $display("FAIL emptypp_count got=%0d want=1", count); else n_pass++;
        n_total++; if (out !== 16'h5A5A) $display("FAIL emptypp_out got=%h want=5a5a", out); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 16'h1111);
        step(1'b0, 1'b1, 1'b0, 16'h2222);
        n_total++; if (count !== 4'd3) $display("FAIL midrst_pre_count got=%0d want=3", count); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        n_total++; if (empty !== 1'b1) $display("FAIL midrst_empty got=%b want=1", empty); else n_pass++;
        n_total++; if (out !== 16'h0000) $display("FAIL midrst_out got=%h want=0000", out); else n_pass++;
        n_total++; if (count !== 4'd0) $display("FAIL midrst_count got=%0d want=0", count); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic p;
            logic q;
            r = ($urandom_range(0, 59) == 0);
            p = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            q = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            step(r, p, q, 16'($urandom));
            n_total++; if (count !== 4'(mq.size())) $display("FAIL rnd_count got=%0d want=%0d", count, mq.size()); else n_pass++;
            n_total++; if (out !== exp_out()) $display("FAIL rnd_out got=%h want=%h", out, exp_out()); else n_pass++;
            n_total++; if (empty !== (mq.size() == 0)) $display("FAIL rnd_empty got=%b want=%b", empty, mq.size() == 0); else n_pass++;
            n_total++; if (full !== (mq.size() == 8)) $display("FAIL rnd_full got=%b want=%b", full, mq.size() == 8); else n_pass++;
            n_total++; if (err !== exp_err) $display("FAIL rnd_err got=%b want=%b", err, exp_err); else n_pass++;
        end
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_full_pushpop();
        test_empty_pushpop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
